// File: rtl/alu_pkg.sv
// Shared definitions for multicycle_alu: opcode values, FSM state encoding and width helpers.
package alu_pkg;

    localparam int unsigned OP_ADD  = 0;
    localparam int unsigned OP_SUB  = 1;
    localparam int unsigned OP_MULT = 2;
    localparam int unsigned OP_DIV  = 3;
    localparam int unsigned OP_MOD  = 4;
    localparam int unsigned OP_LSH  = 5;
    localparam int unsigned OP_RSH  = 6;
    localparam int unsigned OP_AND  = 7;
    localparam int unsigned OP_OR   = 8;
    localparam int unsigned OP_NOT  = 9;
    localparam int unsigned OP_EQ   = 10;
    localparam int unsigned OP_NEQ  = 11;
    localparam int unsigned OP_LT   = 12;
    localparam int unsigned OP_LTE  = 13;
    localparam int unsigned OP_BAND = 14;
    localparam int unsigned OP_BOR  = 15;
    localparam int unsigned OP_BXOR = 16;
    localparam int unsigned OP_ASR  = 17;
    localparam int unsigned OP_DIVS = 18;
    localparam int unsigned OP_MODS = 19;

    typedef enum logic {
        IDLE   = 1'b0,
        DIVIDE = 1'b1
    } aluStateT;

    function automatic int shamtWidth(input int width);
        return $clog2(width);
    endfunction

    function automatic logic isDivOp(input logic [31:0] op);
        return (op == OP_DIV) || (op == OP_MOD) || (op == OP_DIVS) || (op == OP_MODS);
    endfunction

    function automatic logic isSignedDivOp(input logic [31:0] op);
        return (op == OP_DIVS) || (op == OP_MODS);
    endfunction

    function automatic logic isModOp(input logic [31:0] op);
        return (op == OP_MOD) || (op == OP_MODS);
    endfunction

    // Unknown opcodes execute as ADD, so they share ADD's carry behaviour.
    function automatic logic isAddLike(input logic [31:0] op);
        return (op == OP_ADD) || (op > OP_MODS);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; start loads operands.
// Latency: WIDTH iterations after start; done is high during the final iteration, with its result on quotient/remainder.
// Backpressure: none; the caller must not pulse start while an iteration is running.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = shamtWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             running;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             stepFits;

    // Dividend bits shift out of quoReg into the partial remainder while quotient bits shift in.
    assign shifted   = {remReg, quoReg[WIDTH-1]};
    assign diff      = shifted - {1'b0, divisorReg};
    assign stepFits  = !diff[WIDTH];
    assign quotient  = {quoReg[WIDTH-2:0], stepFits};
    assign remainder = stepFits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign done      = running && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            running    <= 1'b0;
            count      <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
        end else if (start) begin
            running    <= 1'b1;
            count      <= '0;
            remReg     <= '0;
            quoReg     <= dividend;
            divisorReg <= divisor;
        end else if (running) begin
            remReg  <= remainder;
            quoReg  <= quotient;
            count   <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU with registered result and iterative DIV/MOD; optional flag outputs under ALU_FLAGS_EN.
// Latency: 1 cycle for single-cycle ops and zero-divisor cases, DATA_WIDTH+1 cycles for divisions.
// Backpressure: result holds until outValid && outReady; inReady drops while dividing or holding an unconsumed result.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [OPCODE_WIDTH-1:0] opCode,
    input  logic [DATA_WIDTH-1:0]   inputData1,
    input  logic [DATA_WIDTH-1:0]   inputData2,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [DATA_WIDTH-1:0]   outputData,
    output logic                    divByZero,
`ifdef ALU_FLAGS_EN
    output logic                    zeroFlag,
    output logic                    negFlag,
    output logic                    carryFlag,
`endif
    output logic                    busy
);

    localparam int SHAMT_WIDTH = shamtWidth(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] WIDTH_LIMIT = DATA_WIDTH'(DATA_WIDTH);

    aluStateT                state;
    aluStateT                stateNext;
    logic [31:0]             opWord;
    logic                    accept;
    logic                    opIsDiv;
    logic                    divSignedOp;
    logic                    divZero;
    logic                    shiftOver;
    logic [SHAMT_WIDTH-1:0]  shamt;
    logic [DATA_WIDTH-1:0]   aluResult;
    logic [DATA_WIDTH-1:0]   dividendMag;
    logic [DATA_WIDTH-1:0]   divisorMag;
    logic                    divStart;
    logic                    divDone;
    logic [DATA_WIDTH-1:0]   divQuo;
    logic [DATA_WIDTH-1:0]   divRem;
    logic [DATA_WIDTH-1:0]   divResult;
    logic                    negQuo;
    logic                    negRem;
    logic                    modSel;
    logic                    capture;
    logic [DATA_WIDTH-1:0]   capData;
    logic                    capDbz;
    logic                    outValidNext;

    assign opWord      = 32'(opCode);
    assign inReady     = (state == IDLE) && (!outValid || outReady);
    assign accept      = inValid && inReady;
    assign busy        = (state == DIVIDE);
    assign opIsDiv     = isDivOp(opWord);
    assign divSignedOp = isSignedDivOp(opWord);
    assign divZero     = (inputData2 == '0);
    assign shiftOver   = (inputData2 >= WIDTH_LIMIT);
    assign shamt       = inputData2[SHAMT_WIDTH-1:0];

    always_comb begin
        aluResult = inputData1 + inputData2;
        case (opWord)
            OP_SUB:          aluResult = inputData1 - inputData2;
            OP_MULT:         aluResult = inputData1 * inputData2;
            OP_DIV, OP_DIVS: aluResult = '1;
            OP_MOD, OP_MODS: aluResult = inputData1;
            OP_LSH:          aluResult = shiftOver ? '0 : (inputData1 << shamt);
            OP_RSH:          aluResult = shiftOver ? '0 : (inputData1 >> shamt);
            OP_AND:          aluResult = DATA_WIDTH'((inputData1 != '0) && (inputData2 != '0));
            OP_OR:           aluResult = DATA_WIDTH'((inputData1 != '0) || (inputData2 != '0));
            OP_NOT:          aluResult = DATA_WIDTH'(inputData1 == '0);
            OP_EQ:           aluResult = DATA_WIDTH'(inputData1 == inputData2);
            OP_NEQ:          aluResult = DATA_WIDTH'(inputData1 != inputData2);
            OP_LT:           aluResult = DATA_WIDTH'($signed(inputData1) < $signed(inputData2));
            OP_LTE:          aluResult = DATA_WIDTH'($signed(inputData1) <= $signed(inputData2));
            OP_BAND:         aluResult = inputData1 & inputData2;
            OP_BOR:          aluResult = inputData1 | inputData2;
            OP_BXOR:         aluResult = inputData1 ^ inputData2;
            OP_ASR:          aluResult = shiftOver ? {DATA_WIDTH{inputData1[DATA_WIDTH-1]}}
                                                   : $unsigned($signed(inputData1) >>> shamt);
            default:         aluResult = inputData1 + inputData2;
        endcase
    end

    // MIN / -1 needs no special case: |MIN| is MIN as unsigned, and negating it wraps back to MIN.
    assign dividendMag = (divSignedOp && inputData1[DATA_WIDTH-1]) ? -inputData1 : inputData1;
    assign divisorMag  = (divSignedOp && inputData2[DATA_WIDTH-1]) ? -inputData2 : inputData2;
    assign divResult   = modSel ? (negRem ? -divRem : divRem) : (negQuo ? -divQuo : divQuo);

    alu_divider #(
        .WIDTH(DATA_WIDTH)
    ) uDivider (
        .clock    (clock),
        .reset    (reset),
        .start    (divStart),
        .dividend (dividendMag),
        .divisor  (divisorMag),
        .done     (divDone),
        .quotient (divQuo),
        .remainder(divRem)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext    = state;
        capture      = 1'b0;
        capData      = aluResult;
        capDbz       = 1'b0;
        divStart     = 1'b0;
        outValidNext = outValid;
        case (state)
            IDLE: begin
                if (outValid && outReady) begin
                    outValidNext = 1'b0;
                end
                if (accept) begin
                    if (opIsDiv && !divZero) begin
                        divStart  = 1'b1;
                        stateNext = DIVIDE;
                    end else begin
                        capture      = 1'b1;
                        capDbz       = opIsDiv;
                        outValidNext = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (divDone) begin
                    stateNext    = IDLE;
                    capture      = 1'b1;
                    capData      = divResult;
                    outValidNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outValid   <= 1'b0;
            outputData <= '0;
            divByZero  <= 1'b0;
            negQuo     <= 1'b0;
            negRem     <= 1'b0;
            modSel     <= 1'b0;
        end else begin
            outValid <= outValidNext;
            if (capture) begin
                outputData <= capData;
                divByZero  <= capDbz;
            end
            if (divStart) begin
                negQuo <= divSignedOp && (inputData1[DATA_WIDTH-1] ^ inputData2[DATA_WIDTH-1]);
                negRem <= divSignedOp && inputData1[DATA_WIDTH-1];
                modSel <= isModOp(opWord);
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic [DATA_WIDTH:0] addWide;
    logic                carryNext;

    assign addWide = {1'b0, inputData1} + {1'b0, inputData2};

    always_comb begin
        carryNext = 1'b0;
        if (state == IDLE) begin
            if (opWord == OP_SUB) begin
                carryNext = (inputData1 < inputData2);
            end else if (isAddLike(opWord)) begin
                carryNext = addWide[DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            zeroFlag  <= 1'b0;
            negFlag   <= 1'b0;
            carryFlag <= 1'b0;
        end else if (capture) begin
            zeroFlag  <= (capData == '0);
            negFlag   <= capData[DATA_WIDTH-1];
            carryFlag <= carryNext;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and randomized checks of multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

    logic        clock;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [5:0]  opCode;
    logic [31:0] inputData1;
    logic [31:0] inputData2;
    logic        outValid;
    logic        outReady;
    logic [31:0] outputData;
    logic        divByZero;
    logic        busy;
`ifdef ALU_FLAGS_EN
    logic        zeroFlag;
    logic        negFlag;
    logic        carryFlag;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_alu #(
        .DATA_WIDTH  (32),
        .OPCODE_WIDTH(6)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .inValid   (inValid),
        .inReady   (inReady),
        .opCode    (opCode),
        .inputData1(inputData1),
        .inputData2(inputData2),
        .outValid  (outValid),
        .outReady  (outReady),
        .outputData(outputData),
        .divByZero (divByZero),
`ifdef ALU_FLAGS_EN
        .zeroFlag  (zeroFlag),
        .negFlag   (negFlag),
        .carryFlag (carryFlag),
`endif
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result {divByZero, data} from the arithmetic meaning of each opcode.
    function automatic logic [32:0] refModel(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [31:0] r;
        logic        dbz;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        case (op)
            1:  r = a - b;
            2:  r = a * b;
            3:  if (b == 0) begin r = 32'hFFFF_FFFF; dbz = 1'b1; end else r = a / b;
            4:  if (b == 0) begin r = a; dbz = 1'b1; end else r = a % b;
            5:  r = (b >= 32) ? 32'd0 : (a << b);
            6:  r = (b >= 32) ? 32'd0 : (a >> b);
            7:  r = {31'd0, (a != 0) && (b != 0)};
            8:  r = {31'd0, (a != 0) || (b != 0)};
            9:  r = {31'd0, a == 0};
            10: r = {31'd0, a == b};
            11: r = {31'd0, a != b};
            12: r = {31'd0, sa < sb};
            13: r = {31'd0, sa <= sb};
            14: r = a & b;
            15: r = a | b;
            16: r = a ^ b;
            17: r = (b >= 32) ? {32{a[31]}} : 32'(sa >>> b);
            18: if (b == 0) begin r = 32'hFFFF_FFFF; dbz = 1'b1; end else r = 32'(sa / sb);
            19: if (b == 0) begin r = a; dbz = 1'b1; end else r = 32'(sa % sb);
            default: r = a + b;
        endcase
        return {dbz, r};
    endfunction

    function automatic int refLatency(input int unsigned op, input logic [31:0] b);
        if ((op == 3 || op == 4 || op == 18 || op == 19) && b != 0) return 33;
        return 1;
    endfunction

    // Starts and ends on a falling edge; leaves the result visible on outValid.
    task automatic runOp(input string tag, input int unsigned op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expData, input logic expDbz);
        int waitCnt;
        int lat;
        int busyCnt;
        int readyCnt;
        int expLat;
        expLat  = refLatency(op, b);
        waitCnt = 0;
        while (!inReady && waitCnt < 100) begin
            @(negedge clock);
            waitCnt++;
        end
        check({tag, "_inReady"}, 64'(inReady), 64'd1);
        opCode     = 6'(op);
        inputData1 = a;
        inputData2 = b;
        inValid    = 1'b1;
        @(negedge clock);
        inValid  = 1'b0;
        lat      = 1;
        busyCnt  = 0;
        readyCnt = 0;
        while (!outValid && lat < 100) begin
            if (busy) busyCnt++;
            if (inReady) readyCnt++;
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(expLat));
        check({tag, "_data"}, 64'(outputData), 64'(expData));
        check({tag, "_dbz"}, 64'(divByZero), 64'(expDbz));
        if (expLat > 1) begin
            check({tag, "_busyCycles"}, 64'(busyCnt), 64'd32);
            check({tag, "_readyWhileBusy"}, 64'(readyCnt), 64'd0);
        end
`ifdef ALU_FLAGS_EN
        begin
            logic [32:0] wide;
            logic        expCarry;
            wide     = {1'b0, a} + {1'b0, b};
            expCarry = (op == 1) ? (a < b) : ((op == 0 || op > 19) ? wide[32] : 1'b0);
            check({tag, "_zeroFlag"}, 64'(zeroFlag), 64'(expData == 0));
            check({tag, "_negFlag"}, 64'(negFlag), 64'(expData[31]));
            check({tag, "_carryFlag"}, 64'(carryFlag), 64'(expCarry));
        end
`endif
    endtask

    initial begin
        logic [32:0] exp;
        int unsigned op;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        reset      = 1'b1;
        inValid    = 1'b0;
        outReady   = 1'b1;
        opCode     = '0;
        inputData1 = '0;
        inputData2 = '0;
        repeat (3) @(negedge clock);
        check("reset_outValid", 64'(outValid), 64'd0);
        check("reset_outputData", 64'(outputData), 64'd0);
        check("reset_divByZero", 64'(divByZero), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_inReady", 64'(inReady), 64'd1);

        runOp("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        runOp("div_100_7", 3, 32'd100, 32'd7, 32'd14, 1'b0);
        runOp("mod_100_7", 4, 32'd100, 32'd7, 32'd2, 1'b0);
        runOp("divs_m7_2", 18, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        runOp("mods_m7_2", 19, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        runOp("divs_ovf", 18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        runOp("mods_ovf", 19, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        runOp("div_5_0", 3, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        runOp("mod_5_0", 4, 32'd5, 32'd0, 32'd5, 1'b1);
        runOp("asr_40", 17, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, 1'b0);
        runOp("lsh_32", 5, 32'h0000_0001, 32'd32, 32'd0, 1'b0);
        runOp("unknown_op", 63, 32'd20, 32'd22, 32'd42, 1'b0);

        // Hold a SUB result for four cycles while a new request waits.
        @(negedge clock);
        outReady = 1'b0;
        runOp("sub_hold", 1, 32'd10, 32'd3, 32'd7, 1'b0);
        opCode     = 6'd0;
        inputData1 = 32'd1;
        inputData2 = 32'd1;
        inValid    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("hold_outValid", 64'(outValid), 64'd1);
            check("hold_data", 64'(outputData), 64'd7);
            check("hold_inReady", 64'(inReady), 64'd0);
        end
        outReady = 1'b1;
        @(negedge clock);
        inValid = 1'b0;
        check("release_outValid", 64'(outValid), 64'd1);
        check("release_data", 64'(outputData), 64'd2);
        @(negedge clock);
        check("release_drained", 64'(outValid), 64'd0);

        // Reset at iteration 10 of a division aborts it and drops the result.
        opCode     = 6'd3;
        inputData1 = 32'd1000;
        inputData2 = 32'd3;
        inValid    = 1'b1;
        @(negedge clock);
        inValid = 1'b0;
        repeat (10) @(negedge clock);
        check("midiv_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("midiv_rst_outValid", 64'(outValid), 64'd0);
        check("midiv_rst_busy", 64'(busy), 64'd0);
        check("midiv_rst_inReady", 64'(inReady), 64'd1);
        reset = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(negedge clock);
            if (outValid || busy) seen++;
        end
        check("midiv_result_dropped", 64'(seen), 64'd0);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 21);
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(0, 40));
                2:       b = 32'hFFFF_FFFF;
                default: b = 32'($urandom);
            endcase
            exp = refModel(op, a, b);
            runOp($sformatf("rand%0d_op%0d", i, op), op, a, b, exp[31:0], exp[32]);
        end

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
